reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
Circular in-order reorder buffer (ROB) beside the rename map table.
- Allocates ROB tags at dispatch; the map table consumes them through assign_flag / assign_rob_tag_reg.
- Captures CDB results and supplies completed-but-uncommitted operand values.
- Retires the head entry in order, driving the map table's return_flag, reg_addr_from_rob and rob_tag_from_rob, plus the regfile write.

Parameters:
ROB_TAG_LEN, `ROB_TAG_LEN, tag width; tag value all-ones is reserved as "no tag" and is never allocated.
ROB_SIZE, (1<<`ROB_TAG_LEN)-1, number of entries; tags 0..ROB_SIZE-1.
REG_ADDR_LEN, `REG_ADDR_LEN, architectural register address width.
XLEN, `XLEN, data width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous squash of all entries (mispredict).
dispatch_valid  in  1  dispatch requests allocation this cycle.
dispatch_dest  in  REG_ADDR_LEN  destination arch register of the dispatching instruction.
dispatch_ready  out  1  ROB not full; allocation accepted iff dispatch_valid && dispatch_ready.
assign_rob_tag  out  ROB_TAG_LEN  tag to be allocated (= tail pointer).
cdb_valid  in  1  CDB broadcast valid.
cdb_rob_tag  in  ROB_TAG_LEN  completing tag.
cdb_value  in  XLEN  result value.
src1_rob_tag  in  ROB_TAG_LEN  operand-1 lookup tag.
src1_value  out  XLEN  value stored in that entry.
src2_rob_tag  in  ROB_TAG_LEN  operand-2 lookup tag.
src2_value  out  XLEN  value stored in that entry.
commit_valid  out  1  head retires this cycle (map table return_flag).
commit_reg_addr  out  REG_ADDR_LEN  head destination.
commit_rob_tag  out  ROB_TAG_LEN  head tag.
commit_value  out  XLEN  head value (regfile write data).

Behaviour:
- State: head, tail (ROB_TAG_LEN bits) and count (0..ROB_SIZE). Per entry: valid, ready, dest, value.
- Reset (async): head=tail=count=0; all valid=ready=0; values 0. Outputs after reset: dispatch_ready=1, assign_rob_tag=0, commit_valid=0, commit_* =0, srcN_value=0.
- Full: count==ROB_SIZE. Empty: count==0.
- dispatch_ready = !full. It is deliberately not relieved by a same-cycle commit.
- Accepted dispatch, at the next edge:
  - entry[tail] gets valid=1, ready=0, dest=dispatch_dest, value=0.
  - tail advances; wrap is ROB_SIZE-1 -> 0, so tag all-ones is never produced.
  - Dest 0 is allocated normally.
- CDB write: if cdb_valid && cdb_rob_tag<ROB_SIZE && entry valid, then ready<=1 and value<=cdb_value. Otherwise the broadcast is ignored, including tag all-ones.
- Commit is combinational from registered state.
  - commit_valid = !empty && entry[head].ready.
  - commit_* reflect the head entry whenever commit_valid=1; otherwise they are 0.
  - On commit_valid the head entry is cleared and head advances with the same wrap rule.
- Latency: a CDB write to the head entry gives commit_valid on the following cycle, never the same cycle.
- count update: +1 on accepted dispatch, -1 on commit, unchanged when both happen.
- Dispatch when empty: the new entry cannot commit in the same cycle.
- Simultaneous events:
  - dispatch, CDB and commit may occur in the same cycle and act on distinct entries.
  - A CDB write targeting the entry being committed has no effect.
- flush, at the next edge:
  - all valid/ready cleared; head=tail=count=0.
  - Same-cycle dispatch and CDB are discarded.
  - commit_valid in the flush cycle still asserts if the head is ready, i.e. the older instruction retires.
- Operand read: srcN_value = entry[srcN_rob_tag].value, combinational. For tag >= ROB_SIZE the output is 0.
- Reset mid-operation: immediate return to the reset state regardless of clk.

Optional Feature:
Macro ROB_CDB_BYPASS_EN.
- Defined: if cdb_valid && cdb_rob_tag==srcN_rob_tag and the entry is valid, srcN_value=cdb_value in the same cycle (forwarding ahead of the register write).
- Undefined: srcN_value comes from the registered entry only; a CDB result becomes visible one cycle later.

Decomposition:
- Header rob.svh holds:
  - typedef ROB_ENTRY {valid, ready, dest, value};
  - macros `ROB_SIZE and `ROB_NO_TAG (all-ones).
- Widths come from sys_defs.svh.
- One natural sub-module: rob_ptr, a wrapping pointer with increment-enable, sync clear and async reset, instantiated for head and tail.

Test Plan:
- Reset, then 3 dispatches with dest 5, 6, 7 -> assign_rob_tag reads 0, 1, 2 on successive cycles; count=3; commit_valid=0.
- CDB tag 1 value 0xAA, then CDB tag 0 value 0x55 -> one cycle after tag 0 completes, commit reg 5 value 0x55 tag 0; next cycle commit reg 6 value 0xAA tag 1 (in order).
- 7 dispatches with no completions -> dispatch_ready=0 after the 7th. An 8th request is not allocated and the tail stays 0 after wrap. The tag 7 (all-ones) is never output.
- Full ROB with head ready, plus dispatch_valid -> commit occurs; dispatch is refused that cycle and accepted the next cycle with tag 0.
- flush with 4 entries and head ready, plus a same-cycle dispatch and CDB -> head commits; next cycle count=0, assign_rob_tag=0, commit_valid=0.
- With ROB_CDB_BYPASS_EN: src1_rob_tag=2 and CDB tag 2 value 0x1234 in the same cycle -> src1_value=0x1234 that cycle. Without the macro -> 0 that cycle, 0x1234 the next.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer.
// Tag value all-ones is reserved as "no tag"; the ring holds (1<<ROB_TAG_LEN)-1 entries.
// Optional build macro used by the top: ROB_CDB_BYPASS_EN (CDB-to-operand forwarding).
package reorder_buffer_pkg;

  localparam int ROB_TAG_LEN  = 3;
  localparam int REG_ADDR_LEN = 5;
  localparam int XLEN         = 32;
  localparam int ROB_SIZE     = (1 << ROB_TAG_LEN) - 1;

  typedef logic [ROB_TAG_LEN-1:0] rob_tag_t;

  // Reserved "no tag" marker; never allocated, never produced by a pointer.
  localparam rob_tag_t ROB_NO_TAG     = '1;
  localparam rob_tag_t ROB_LAST_TAG   = rob_tag_t'(ROB_SIZE - 1);
  localparam rob_tag_t ROB_FULL_COUNT = rob_tag_t'(ROB_SIZE);

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [XLEN-1:0]         value;
  } rob_entry_t;

  // Ring successor: the last real tag wraps to 0, skipping the reserved tag.
  function automatic rob_tag_t rob_next(input rob_tag_t ptr);
    return (ptr == ROB_LAST_TAG) ? '0 : rob_tag_t'(ptr + 1'b1);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping ring pointer for the reorder buffer (used for head and tail).
// Sync clear has priority over increment; wrap skips the reserved tag.
module rob_ptr
  import reorder_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [ROB_TAG_LEN-1:0] ptr
);

  // Pointer register: cleared on flush, otherwise steps when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= rob_next(ptr);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer beside the rename map table.
// Allocates tags at dispatch, captures CDB results, serves operand values,
// and retires the head entry in order.
// Build option: define ROB_CDB_BYPASS_EN to forward a same-cycle CDB result
// onto the operand read ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
  output logic                    dispatch_ready,
  output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
  input  logic                    cdb_valid,
  input  logic [ROB_TAG_LEN-1:0]  cdb_rob_tag,
  input  logic [XLEN-1:0]         cdb_value,
  input  logic [ROB_TAG_LEN-1:0]  src1_rob_tag,
  output logic [XLEN-1:0]         src1_value,
  input  logic [ROB_TAG_LEN-1:0]  src2_rob_tag,
  output logic [XLEN-1:0]         src2_value,
  output logic                    commit_valid,
  output logic [REG_ADDR_LEN-1:0] commit_reg_addr,
  output logic [ROB_TAG_LEN-1:0]  commit_rob_tag,
  output logic [XLEN-1:0]         commit_value
);

  rob_entry_t             rob [ROB_SIZE];
  logic [ROB_TAG_LEN-1:0] head;
  logic [ROB_TAG_LEN-1:0] tail;
  logic [ROB_TAG_LEN-1:0] count;

  logic       full;
  logic       empty;
  logic       accept;
  logic       cdb_hit;
  rob_entry_t head_entry;
  logic       cdb_entry_valid;

  rob_ptr u_head (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (commit_valid),
    .ptr   (head)
  );

  rob_ptr u_tail (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (accept),
    .ptr   (tail)
  );

  // Occupancy flags and dispatch handshake; a same-cycle commit does not relieve full.
  always_comb begin
    full           = (count == ROB_FULL_COUNT);
    empty          = (count == '0);
    dispatch_ready = !full;
    accept         = dispatch_valid && !full;
    assign_rob_tag = tail;
  end

  // Head lookup and in-order retire decision, purely from registered state.
  always_comb begin
    head_entry      = (head == ROB_NO_TAG) ? '0 : rob[head];
    commit_valid    = !empty && head_entry.valid && head_entry.ready;
    commit_reg_addr = commit_valid ? head_entry.dest : '0;
    commit_rob_tag  = commit_valid ? head : '0;
    commit_value    = commit_valid ? head_entry.value : '0;
  end

  // CDB acceptance: real tag, live entry, and not the entry retiring this cycle.
  always_comb begin
    cdb_entry_valid = (cdb_rob_tag == ROB_NO_TAG) ? 1'b0 : rob[cdb_rob_tag].valid;
    cdb_hit         = cdb_valid && cdb_entry_valid &&
                      !(commit_valid && (cdb_rob_tag == head));
  end

`ifdef ROB_CDB_BYPASS_EN
  logic src1_live;
  logic src2_live;

  // Operand reads with same-cycle CDB forwarding onto live entries.
  always_comb begin
    src1_live  = (src1_rob_tag == ROB_NO_TAG) ? 1'b0 : rob[src1_rob_tag].valid;
    src2_live  = (src2_rob_tag == ROB_NO_TAG) ? 1'b0 : rob[src2_rob_tag].valid;
    src1_value = (src1_rob_tag == ROB_NO_TAG) ? '0 : rob[src1_rob_tag].value;
    src2_value = (src2_rob_tag == ROB_NO_TAG) ? '0 : rob[src2_rob_tag].value;
    if (cdb_valid && (cdb_rob_tag == src1_rob_tag) && src1_live) begin
      src1_value = cdb_value;
    end
    if (cdb_valid && (cdb_rob_tag == src2_rob_tag) && src2_live) begin
      src2_value = cdb_value;
    end
  end
`else
  // Operand reads from registered entries only; CDB data shows up a cycle later.
  always_comb begin
    src1_value = (src1_rob_tag == ROB_NO_TAG) ? '0 : rob[src1_rob_tag].value;
    src2_value = (src2_rob_tag == ROB_NO_TAG) ? '0 : rob[src2_rob_tag].value;
  end
`endif

  // Entry storage: flush squashes liveness, CDB fills, dispatch allocates, commit clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i] <= '0;
      end
    end else begin
      if (flush) begin
        // Values are kept; only liveness is dropped. Same-cycle dispatch/CDB are lost.
        for (int i = 0; i < ROB_SIZE; i++) begin
          rob[i].valid <= 1'b0;
          rob[i].ready <= 1'b0;
        end
      end else begin
        if (cdb_hit) begin
          rob[cdb_rob_tag].ready <= 1'b1;
          rob[cdb_rob_tag].value <= cdb_value;
        end
        if (accept) begin
          rob[tail] <= '{valid: 1'b1, ready: 1'b0, dest: dispatch_dest, value: '0};
        end
      end
      // Retiring head is wiped, also in a flush cycle (the older instruction retires).
      if (commit_valid) begin
        rob[head] <= '0;
      end
    end
  end

  // Occupancy counter: dispatch and commit in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({accept, commit_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
